glitc_conf_loader: RTL

- Downstream partner of the GLITC configuration controller: once a GLITC has had PROGRAM_B pulsed and INIT_B has risen, software streams its bitstream through this block.
- WISHBONE slave accepts 32-bit bitstream words into a small FIFO.
- A serializer shifts each word MSB-first onto a shared slave-serial bus (CCLK/DIN).
- Monitors the selected GLITC's INIT_B (CRC error) and DONE, then issues startup clocks.

---
 rtl/glitc_conf_loader.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/glitc_conf_loader.sv
// glitc_conf_loader
//   Streams a GLITC bitstream written over WISHBONE onto the shared
//   slave-serial configuration bus. Software pushes 32-bit words into a
//   small first-word-fall-through FIFO. A serializer shifts each word
//   MSB-first on DIN, and the GLITC samples DIN on every CCLK rising edge.
//   The selected GLITC's INIT_B is watched for a CRC error. Its DONE is
//   watched for configuration complete, after which a burst of startup
//   clocks is issued.
//
// Ports
//   clk_i, rst_i        system clock, synchronous active-high reset
//   cyc_i, stb_i, we_i  WISHBONE cycle / strobe / write enable
//   adr_i[4:0]          word address, only [1:0] decoded (0 CTRL, 1 DATA)
//   sel_i[3:0]          byte selects, ignored (full-word access only)
//   dat_i / dat_o       write / read data
//   ack_o, rty_o        acknowledge / retry (DATA write while FIFO full)
//   err_o               always 0
//   CCLK, DIN           shared configuration clock and serial data
//   INIT_B[3:0]         per-GLITC INIT_B (low = CRC error)
//   DONE[3:0]           per-GLITC DONE

module glitc_conf_loader #(
  parameter int FIFO_AW      = 4,
  parameter int CCLK_HALF    = 2,
  parameter int STARTUP_CLKS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        rty_o,
  output logic        err_o,
  output logic        CCLK,
  output logic        DIN,
  input  logic [3:0]  INIT_B,
  input  logic [3:0]  DONE
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HCW   = (CCLK_HALF > 1) ? $clog2(CCLK_HALF) : 1;
  localparam int SCW   = (STARTUP_CLKS > 1) ? $clog2(STARTUP_CLKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_START_LO,
    S_START_HI,
    S_ERROR
  } state_t;

  state_t             r_state;
  logic               r_pend;
  logic [1:0]         r_target;
  logic [1:0]         r_curTarget;
  logic               r_enable;
  logic               r_crcErr;
  logic               r_doneSeen;
  logic               r_doneFlag;
  logic [30:0]        r_shifter;
  logic [4:0]         r_bitCnt;
  logic [HCW-1:0]     r_halfCnt;
  logic [SCW-1:0]     r_startCnt;
  logic [3:0]         r_initMeta, r_initSync;
  logic [3:0]         r_doneMeta, r_doneSync;

  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr, r_rdPtr;
  logic [FIFO_AW:0]   r_count;

  logic               w_req, w_isData, w_full, w_empty, w_retry;
  logic               w_push, w_pop, w_ctrlWr, w_flush, w_clrCrc;
  logic               w_busy, w_halfEnd, w_initSel, w_doneSel, w_doneNow;
  logic               w_initErr, w_startWord, w_nextWord;
  logic [31:0]        w_head;
  logic               w_unused;

  // WISHBONE decode. The ack register follows a request by one cycle and is
  // re-gated with cyc/stb so that an aborted cycle never sees a stale ack.
  // A DATA write into a full FIFO answers with retry in the ack slot.
  assign w_req    = cyc_i & stb_i;
  assign w_isData = (adr_i[1:0] == 2'd1);
  assign w_full   = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_retry  = we_i & w_isData & w_full;
  assign ack_o    = r_pend & w_req & ~w_retry;
  assign rty_o    = r_pend & w_req & w_retry;
  assign err_o    = 1'b0;
  assign w_push   = ack_o & we_i & w_isData;
  assign w_ctrlWr = ack_o & we_i & (adr_i[1:0] == 2'd0);
  assign w_flush  = w_ctrlWr & dat_i[5];
  assign w_clrCrc = w_ctrlWr & dat_i[6];
  assign w_unused = ^{sel_i, adr_i[4:2]};

  // FSM status terms. The active target is latched while idle so that
  // a CTRL write during a transfer only takes effect at the next IDLE.
  assign w_busy      = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign w_halfEnd   = (r_halfCnt == HCW'(CCLK_HALF - 1));
  assign w_initSel   = r_initSync[r_curTarget];
  assign w_doneSel   = r_doneSync[r_curTarget];
  assign w_doneNow   = r_doneFlag | w_doneSel;
  assign w_initErr   = w_busy & ~w_initSel & ~w_doneSel;
  assign w_head      = r_mem[r_rdPtr];
  assign w_startWord = (r_state == S_IDLE) & r_enable & ~w_empty &
                       r_initSync[r_target] & ~w_flush;
  assign w_nextWord  = (r_state == S_SHIFT_HI) & w_halfEnd & (r_bitCnt == 5'd0) &
                       ~w_doneNow & ~w_empty & ~w_initErr & ~w_flush;
  assign w_pop       = w_startWord | w_nextWord;

  // The ack slot lasts one cycle per request. Back-to-back requests with
  // stb held high are acknowledged every other cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_req & ~r_pend;
    end
  end

  // The storage array has no reset. Only the pointers and count define
  // which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= dat_i;
    end
  end

  // FIFO pointers and occupancy. A flush discards everything queued.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Two-flop synchronizers for the asynchronous GLITC status pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_initMeta <= '0;
      r_initSync <= '0;
      r_doneMeta <= '0;
      r_doneSync <= '0;
    end else begin
      r_initMeta <= INIT_B;
      r_initSync <= r_initMeta;
      r_doneMeta <= DONE;
      r_doneSync <= r_doneMeta;
    end
  end

  // Control registers and serializer FSM. CCLK and DIN are registered
  // outputs. DIN is set up at the start of each low half-period, so the
  // GLITC always sees a full half-period of setup before the rising edge.
  // r_shifter holds only the bits still to be presented after the
  // current DIN bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      CCLK        <= 1'b0;
      DIN         <= 1'b0;
      r_target    <= 2'd0;
      r_curTarget <= 2'd0;
      r_enable    <= 1'b0;
      r_crcErr    <= 1'b0;
      r_doneSeen  <= 1'b0;
      r_doneFlag  <= 1'b0;
      r_shifter   <= '0;
      r_bitCnt    <= '0;
      r_halfCnt   <= '0;
      r_startCnt  <= '0;
    end else begin
      if (w_ctrlWr) begin
        r_target <= dat_i[1:0];
        r_enable <= dat_i[4];
      end
      if (w_clrCrc) begin
        r_crcErr <= 1'b0;
      end

      if (w_flush) begin
        r_state    <= S_IDLE;
        CCLK       <= 1'b0;
        DIN        <= 1'b0;
        r_doneFlag <= 1'b0;
        r_halfCnt  <= '0;
      end else if (w_initErr) begin
        r_state    <= S_ERROR;
        CCLK       <= 1'b0;
        r_crcErr   <= 1'b1;
        r_doneFlag <= 1'b0;
        r_halfCnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            CCLK        <= 1'b0;
            r_halfCnt   <= '0;
            r_curTarget <= r_target;
            if (w_startWord) begin
              DIN       <= w_head[31];
              r_shifter <= w_head[30:0];
              r_bitCnt  <= 5'd31;
              r_state   <= S_SHIFT_LO;
            end
          end

          S_SHIFT_LO: begin
            if (w_doneSel) begin
              r_doneFlag <= 1'b1;
              r_doneSeen <= 1'b1;
            end
            if (w_halfEnd) begin
              r_halfCnt <= '0;
              CCLK      <= 1'b1;
              r_state   <= S_SHIFT_HI;
            end else begin
              r_halfCnt <= r_halfCnt + 1'b1;
            end
          end

          S_SHIFT_HI: begin
            if (w_doneSel) begin
              r_doneFlag <= 1'b1;
              r_doneSeen <= 1'b1;
            end
            if (w_halfEnd) begin
              r_halfCnt <= '0;
              CCLK      <= 1'b0;
              if (r_bitCnt != 5'd0) begin
                DIN       <= r_shifter[30];
                r_shifter <= {r_shifter[29:0], 1'b0};
                r_bitCnt  <= r_bitCnt - 1'b1;
                r_state   <= S_SHIFT_LO;
              end else if (w_doneNow) begin
                // The current word is complete, so startup can begin now.
                DIN        <= 1'b1;
                r_doneFlag <= 1'b0;
                r_startCnt <= '0;
                r_state    <= S_START_LO;
              end else if (w_nextWord) begin
                DIN       <= w_head[31];
                r_shifter <= w_head[30:0];
                r_bitCnt  <= 5'd31;
                r_state   <= S_SHIFT_LO;
              end else begin
                DIN     <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_halfCnt <= r_halfCnt + 1'b1;
            end
          end

          S_START_LO: begin
            if (w_halfEnd) begin
              r_halfCnt <= '0;
              CCLK      <= 1'b1;
              r_state   <= S_START_HI;
            end else begin
              r_halfCnt <= r_halfCnt + 1'b1;
            end
          end

          S_START_HI: begin
            if (w_halfEnd) begin
              r_halfCnt <= '0;
              CCLK      <= 1'b0;
              if (r_startCnt == SCW'(STARTUP_CLKS - 1)) begin
                // Configuration is finished. Drop enable so that any
                // leftover words are not sent until software re-arms.
                DIN      <= 1'b0;
                r_enable <= 1'b0;
                r_state  <= S_IDLE;
              end else begin
                r_startCnt <= r_startCnt + 1'b1;
                r_state    <= S_START_LO;
              end
            end else begin
              r_halfCnt <= r_halfCnt + 1'b1;
            end
          end

          S_ERROR: begin
            CCLK <= 1'b0;
            if (w_clrCrc) begin
              r_state <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Read mux: CTRL returns status. DATA and the spare addresses read 0.
  always_comb begin
    dat_o = '0;
    if (adr_i[1:0] == 2'd0) begin
      dat_o[1:0]   = r_target;
      dat_o[4]     = r_enable;
      dat_o[8]     = w_busy;
      dat_o[9]     = r_crcErr;
      dat_o[10]    = r_doneSeen;
      dat_o[11]    = w_empty;
      dat_o[12]    = w_full;
      dat_o[20:16] = 5'(r_count);
    end
  end

endmodule
